// File: rtl/binary_calc_pkg.sv
// Shared definitions for the streaming calculator: opcodes, flag layout,
// frame geometry and FSM state encoding.
package binary_calc_pkg;

    localparam int SEL_W   = 4;
    localparam int FLAGS_W = 4;

    localparam logic [SEL_W-1:0] OP_ADD = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB = 4'd1;
    localparam logic [SEL_W-1:0] OP_MUL = 4'd2;
    localparam logic [SEL_W-1:0] OP_SHL = 4'd3;
    localparam logic [SEL_W-1:0] OP_SHR = 4'd4;
    localparam logic [SEL_W-1:0] OP_AND = 4'd5;
    localparam logic [SEL_W-1:0] OP_OR  = 4'd6;
    localparam logic [SEL_W-1:0] OP_XOR = 4'd7;
    localparam logic [SEL_W-1:0] OP_NOT = 4'd8;
    localparam logic [SEL_W-1:0] OP_INC = 4'd9;
    localparam logic [SEL_W-1:0] OP_DEC = 4'd10;
    localparam logic [SEL_W-1:0] OP_CMP = 4'd11;

    // Bit positions inside the {C,Z,N,V} flag nibble.
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    function automatic int frame_w(input int data_w);
        return 3 * data_w + SEL_W + FLAGS_W;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/binary_calc_stream_fifo.sv
// Synchronous command FIFO with a first-word-fall-through head so the
// entry being popped can be evaluated in the same cycle.
module calc_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/binary_calc_stream.sv
// Streaming calculator: queued commands are evaluated, packed as
// {A, B, Result, Sel, Flags} and serialised MSB first at a programmable rate.
module binary_calc_stream
    import binary_calc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              valid_cmd_i,
    output logic              cmd_ready_o,
    input  logic              config_div_i,
    input  logic [DIV_W-1:0]  din_i,
    output logic [OUT_W-1:0]  data_out_o,
    output logic              dout_valid_o,
    output logic              frame_start_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int FRAME_W = frame_w(DATA_W);
    localparam int BEATS   = FRAME_W / OUT_W;
    localparam int BEAT_W  = $clog2(BEATS + 1);
    localparam int CMD_W   = 2 * DATA_W + SEL_W;
    localparam int MSB     = DATA_W - 1;

    logic [CMD_W-1:0]           fifo_rd_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       fifo_push;
    logic                       fifo_pop;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_reg_q, div_reg_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [FRAME_W-1:0]  shreg_q, shreg_d;
    logic                dout_valid_q, dout_valid_d;
    logic                frame_start_q, frame_start_d;
    logic                overflow_q, overflow_d;

    logic [DATA_W-1:0]   cmd_a, cmd_b;
    logic [SEL_W-1:0]    cmd_sel;
    logic [DATA_W-1:0]   alu_res;
    logic [FLAGS_W-1:0]  alu_flags;
    logic [DATA_W:0]     alu_wide;
    logic                alu_c, alu_v;
    logic                tick;

    assign fifo_push = valid_cmd_i && !fifo_full;
    assign fifo_pop  = (state_q == ST_LOAD) && !fifo_empty;

    calc_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .wr_data_i ({in_a_i, in_b_i, sel_i}),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign cmd_a   = fifo_rd_data[CMD_W-1 -: DATA_W];
    assign cmd_b   = fifo_rd_data[SEL_W+DATA_W-1 -: DATA_W];
    assign cmd_sel = fifo_rd_data[SEL_W-1:0];

    // ALU evaluates the FIFO head; its result is captured only in LOAD.
    always_comb begin
        alu_wide  = '0;
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_flags = '0;
        case (cmd_sel)
            OP_ADD: begin
                alu_wide = {1'b0, cmd_a} + {1'b0, cmd_b};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
                alu_v    = (cmd_a[MSB] == cmd_b[MSB]) && (alu_res[MSB] != cmd_a[MSB]);
            end
            OP_SUB: begin
                alu_wide = {1'b0, cmd_a} - {1'b0, cmd_b};
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
                alu_v    = (cmd_a[MSB] != cmd_b[MSB]) && (alu_res[MSB] != cmd_a[MSB]);
            end
            OP_MUL: alu_res = cmd_a * cmd_b;
            OP_SHL: begin
                alu_res = {cmd_a[DATA_W-2:0], 1'b0};
                alu_c   = cmd_a[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, cmd_a[DATA_W-1:1]};
                alu_c   = cmd_a[0];
            end
            OP_AND: alu_res = cmd_a & cmd_b;
            OP_OR:  alu_res = cmd_a | cmd_b;
            OP_XOR: alu_res = cmd_a ^ cmd_b;
            OP_NOT: alu_res = ~cmd_a;
            OP_INC: begin
                alu_wide = {1'b0, cmd_a} + (DATA_W+1)'(1);
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
                alu_v    = alu_res[MSB] && !cmd_a[MSB];
            end
            OP_DEC: begin
                alu_wide = {1'b0, cmd_a} - (DATA_W+1)'(1);
                alu_res  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
                alu_v    = cmd_a[MSB] && !alu_res[MSB];
            end
            OP_CMP: alu_res = (cmd_a < cmd_b) ? DATA_W'(1) : '0;
            default: alu_res = '0;
        endcase
        if (cmd_sel <= OP_CMP) begin
            alu_flags[FLAG_C] = alu_c;
            alu_flags[FLAG_Z] = (alu_res == '0);
            alu_flags[FLAG_N] = alu_res[MSB];
            alu_flags[FLAG_V] = alu_v;
        end
    end

    assign tick = (div_cnt_q == div_reg_q);

    always_comb begin
        state_d       = state_q;
        div_reg_d     = div_reg_q;
        div_cnt_d     = div_cnt_q;
        beat_d        = beat_q;
        shreg_d       = shreg_q;
        dout_valid_d  = dout_valid_q;
        frame_start_d = 1'b0;
        overflow_d    = overflow_q || (valid_cmd_i && fifo_full);
        case (state_q)
            ST_IDLE: begin
                if (config_div_i && fifo_empty) begin
                    div_reg_d = din_i;
                end
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d       = {cmd_a, cmd_b, alu_res, cmd_sel, alu_flags};
                beat_d        = '0;
                div_cnt_d     = '0;
                dout_valid_d  = 1'b1;
                frame_start_d = 1'b1;
                state_d       = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    div_cnt_d = '0;
                    // Shifting past the last beat leaves the register all-zero.
                    shreg_d   = shreg_q << OUT_W;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        dout_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            div_reg_q     <= '0;
            div_cnt_q     <= '0;
            beat_q        <= '0;
            shreg_q       <= '0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_reg_q     <= div_reg_d;
            div_cnt_q     <= div_cnt_d;
            beat_q        <= beat_d;
            shreg_q       <= shreg_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            overflow_q    <= overflow_d;
        end
    end

    assign data_out_o    = shreg_q[FRAME_W-1 -: OUT_W];
    assign dout_valid_o  = dout_valid_q;
    assign frame_start_o = frame_start_q;
    assign overflow_o    = overflow_q;
    assign cmd_ready_o   = !fifo_full;
    assign busy_o        = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
